// File: rtl/generic_fifo_dc_if.sv
// generic_fifo_dc_if
// Groups the producer/consumer handshake of generic_fifo_dc.
//   slave  : the FIFO side. It takes clr/din/we/re and drives dout and the
//            status flags.
//   master : the user side. It drives clr/din/we/re and observes dout and
//            the status flags.
// clr, we and re are single-cycle strobes in the FIFO clock domain.
interface generic_fifo_dc_if #(
  parameter int dw = 8,
  parameter int aw = 8
);
  logic          clr;
  logic [dw-1:0] din;
  logic          we;
  logic          re;
  logic [dw-1:0] dout;
  logic          full;
  logic          empty;
  logic          full_n;
  logic          empty_n;
  logic [1:0]    level;

  modport slave (
    input  clr, din, we, re,
    output dout, full, empty, full_n, empty_n, level
  );

  modport master (
    output clr, din, we, re,
    input  dout, full, empty, full_n, empty_n, level
  );
endinterface

// File: rtl/generic_fifo_dc.sv
// generic_fifo_dc
// Single-clock FIFO with 2^aw words of dw bits each. It provides exact
// full/empty flags, near-full and near-empty flags with margin n, and a
// 2-bit coarse fill level. A write while full or a read while empty is
// ignored.
// Ports:
//   clk : clock. All state changes happen on its rising edge.
//   rst : asynchronous active-high reset.
//   bus : generic_fifo_dc_if.slave, which carries
//         clr, din, we, re -> dout, full, empty, full_n, empty_n, level.
module generic_fifo_dc #(
  parameter int dw = 8,
  parameter int aw = 8,
  parameter int n  = 9
) (
  input  logic              clk,
  input  logic              rst,
  generic_fifo_dc_if.slave  bus
);

  localparam int         DEPTH     = 1 << aw;
  localparam logic [aw:0] DEPTH_C  = (aw+1)'(DEPTH);
  localparam logic [aw:0] FULL_N_C = (aw+1)'(DEPTH - n);
  localparam logic [aw:0] EMPTY_N_C = (aw+1)'(n);

  logic [dw-1:0] mem_q [DEPTH];
  logic [aw-1:0] wp_q, wp_d;
  logic [aw-1:0] rp_q, rp_d;
  logic [aw:0]   cnt_q, cnt_d;
  logic [dw-1:0] dout_q, dout_d;

  logic full_w, empty_w, we_ok, re_ok;

  // The flags depend only on the registered count. Because of that,
  // we/re/din never reach an output combinationally.
  assign full_w  = (cnt_q == DEPTH_C);
  assign empty_w = (cnt_q == '0);

  // Gating each strobe by its own flag covers the simultaneous cases.
  // When empty, only the write is taken. When full, only the read is taken.
  assign we_ok = bus.we & ~full_w;
  assign re_ok = bus.re & ~empty_w;

  always_comb begin
    wp_d   = wp_q;
    rp_d   = rp_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (bus.clr) begin
      // dout keeps its value across a clear.
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (we_ok) wp_d = wp_q + 1'b1;
      if (re_ok) begin
        rp_d   = rp_q + 1'b1;
        dout_d = mem_q[rp_q];
      end
      case ({we_ok, re_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  // The storage array has no reset. Its contents are don't-care until
  // they are written.
  always_ff @(posedge clk) begin
    if (!bus.clr && we_ok) mem_q[wp_q] <= bus.din;
  end

  assign bus.dout    = dout_q;
  assign bus.full    = full_w;
  assign bus.empty   = empty_w;
  assign bus.full_n  = (cnt_q >= FULL_N_C);
  assign bus.empty_n = (cnt_q <= EMPTY_N_C);
  assign bus.level   = full_w ? 2'b11 : cnt_q[aw-1:aw-2];

endmodule

// File: tb/tb_generic_fifo_dc.sv
module tb_generic_fifo_dc;
  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int NM    = 9;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  generic_fifo_dc_if #(.dw(DW), .aw(AW)) bus ();

  generic_fifo_dc #(.dw(DW), .aw(AW), .n(NM)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: a queue of stored words plus the last word read.
  logic [DW-1:0] q[$];
  logic [DW-1:0] dout_m = '0;
  int            words_rd = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int   cnt;
    logic [1:0] lvl;
    cnt = q.size();
    lvl = (cnt == DEPTH) ? 2'd3 : 2'((cnt * 4) / DEPTH);
    chk({tag, ".empty"},   32'(bus.empty),   32'(cnt == 0));
    chk({tag, ".full"},    32'(bus.full),    32'(cnt == DEPTH));
    chk({tag, ".full_n"},  32'(bus.full_n),  32'(cnt >= DEPTH - NM));
    chk({tag, ".empty_n"}, 32'(bus.empty_n), 32'(cnt <= NM));
    chk({tag, ".level"},   32'(bus.level),   32'(lvl));
    chk({tag, ".dout"},    32'(bus.dout),    32'(dout_m));
  endtask

  // One clock cycle: drive the inputs at the falling edge, update the model
  // at the rising edge, and compare everything 3 ns after that edge.
  task automatic step(input string tag, input logic w, input logic r,
                      input logic [DW-1:0] d, input logic c);
    bit acc_w, acc_r;
    @(negedge clk);
    bus.we = w; bus.re = r; bus.din = d; bus.clr = c;
    @(posedge clk);
    if (c) begin
      q.delete();
    end else begin
      acc_w = w && (q.size() < DEPTH);
      acc_r = r && (q.size() > 0);
      if (acc_r) begin
        dout_m = q.pop_front();
        words_rd++;
      end
      if (acc_w) q.push_back(d);
    end
    #3;
    check_outputs(tag);
  endtask

  task automatic fill_to(input string tag, input int k);
    while (q.size() < k) step(tag, 1'b1, 1'b0, DW'($urandom), 1'b0);
  endtask

  task automatic drain(input string tag);
    while (q.size() > 0) step(tag, 1'b0, 1'b1, '0, 1'b0);
  endtask

  initial begin
    int written;
    int iter;
    int b;

    bus.we = 1'b0; bus.re = 1'b0; bus.din = '0; bus.clr = 1'b0;

    // Reset held for 10 cycles.
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs("reset");

    // Single write followed by a read.
    step("wr_a5", 1'b1, 1'b0, 8'hA5, 1'b0);
    chk("wr_a5_empty_low", 32'(bus.empty), 32'd0);
    step("rd_a5", 1'b0, 1'b1, 8'h00, 1'b0);
    chk("rd_a5_dout", 32'(bus.dout), 32'hA5);
    chk("rd_a5_empty_high", 32'(bus.empty), 32'd1);

    // Fill to full, try a write past full, then read everything back.
    fill_to("fill", DEPTH);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_level", 32'(bus.level), 32'd3);
    step("wr_257", 1'b1, 1'b0, 8'h3C, 1'b0);
    drain("drain_full");

    // Simultaneous write and read while holding 5 words.
    fill_to("fill5", 5);
    repeat (6) step("simul_5", 1'b1, 1'b1, DW'($urandom), 1'b0);
    chk("simul_5_count_kept", 32'(bus.empty_n), 32'd1);
    drain("drain_5");

    // Simultaneous write and read while empty: only the write is taken.
    step("simul_empty", 1'b1, 1'b1, 8'h5A, 1'b0);
    chk("simul_empty_dout_held", 32'(bus.dout), 32'(dout_m));
    drain("drain_1");

    // Simultaneous write and read while full: only the read is taken.
    fill_to("fill_full2", DEPTH);
    step("simul_full", 1'b1, 1'b1, 8'hEE, 1'b0);
    chk("simul_full_not_full", 32'(bus.full), 32'd0);
    drain("drain_full2");

    // Random bursts with wrap-around.
    written = 0;
    iter = 0;
    while (written < 5000 && iter < 20000) begin
      b = $urandom_range(1, 4);
      for (int i = 0; i < b; i++) begin
        if (q.size() < DEPTH) written++;
        step("stress", 1'b1, 1'($urandom % 2), DW'($urandom), 1'b0);
        chk("stress_dout_x", 32'($isunknown(bus.dout)), 32'd0);
        iter++;
      end
      b = $urandom_range(0, 4);
      for (int i = 0; i < b; i++) begin
        step("stress_gap", 1'b0, 1'($urandom % 4 != 0), '0, 1'b0);
        iter++;
      end
    end
    chk("stress_words_done", 32'(written >= 5000), 32'd1);
    drain("stress_drain");

    // Clear while holding 100 words, then one round trip.
    fill_to("fill100", 100);
    step("clr", 1'b1, 1'b1, 8'h11, 1'b1);
    chk("clr_empty", 32'(bus.empty), 32'd1);
    chk("clr_level", 32'(bus.level), 32'd0);
    step("post_clr_wr", 1'b1, 1'b0, 8'hC3, 1'b0);
    step("post_clr_rd", 1'b0, 1'b1, 8'h00, 1'b0);
    chk("post_clr_dout", 32'(bus.dout), 32'hC3);

    // Asynchronous reset in the middle of a cycle, with no clock edge.
    fill_to("fill_pre_rst", 20);
    @(negedge clk);
    bus.we = 1'b0; bus.re = 1'b0; bus.clr = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    dout_m = '0;
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("after_rst_wr", 1'b1, 1'b0, 8'h77, 1'b0);
    step("after_rst_rd", 1'b0, 1'b1, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
